pipe_stage_reg: RTL

- Parametrised elastic pipeline register that replaces the bare IF/ID, ID/EX, EX/MEM and MEM/WB flops.
- Carries any packed payload (WIDTH bits) through a valid/ready handshake, with a DEPTH-entry skid FIFO.
- in_ready is registered, with no combinational path from out_ready, so backpressure paths are cut between stages.
- Supports a synchronous flush that kills every in-flight entry (branch mispredict, trap).

---
 rtl/pipelinestages_pkg.sv | 39 +++
 rtl/pipe_stage_reg_if.sv | 21 ++
 rtl/pipe_stage_reg.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pipelinestages_pkg.sv
// rtl/pipelinestages_pkg.sv - pipeline stage payload types and shared pipeline constants
package pipelinestages_pkg;

    localparam int PIPE_STAGE_MAX_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        wb_en;
    } mem_wb_t;

    // Modulo-depth increment; handles non-power-of-2 depths.
    function automatic int unsigned ptr_wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr + 1 >= depth) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - upstream/downstream valid-ready handshake bundle for pipe_stage_reg
interface pipe_stage_reg_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic pipeline register with skid FIFO and flush; PIPE_STAGE_STATS_EN adds stall/bubble counters
module pipe_stage_reg
    import pipelinestages_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    pipe_stage_reg_if.slave  bus,
    output logic [CNT_W-1:0] count_o
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]      stall_cnt_o,
    output logic [31:0]      bubble_cnt_o
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MEM_N = 1 << PTR_W;

    if (DEPTH < 1 || DEPTH > PIPE_STAGE_MAX_DEPTH) begin : g_bad_depth
        $error("pipe_stage_reg: DEPTH outside 1..PIPE_STAGE_MAX_DEPTH");
    end

    logic [WIDTH-1:0] mem_q [MEM_N];
    logic [WIDTH-1:0] mem_d [MEM_N];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    // Ready/valid decode only from registered occupancy: no out_ready -> in_ready path.
    assign bus.in_ready  = (count_q != CNT_W'(DEPTH));
    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign count_o       = count_q;

    assign push = bus.in_valid  & bus.in_ready  & ~flush_i;
    assign pop  = bus.out_valid & bus.out_ready & ~flush_i;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = bus.in_data;
                wr_ptr_d = PTR_W'(ptr_wrap_inc(32'(wr_ptr_q), unsigned'(DEPTH)));
            end
            if (pop) begin
                rd_ptr_d = PTR_W'(ptr_wrap_inc(32'(rd_ptr_q), unsigned'(DEPTH)));
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_N; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (flush_i) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (bus.out_valid && !bus.out_ready && (stall_cnt_q != '1))
                stall_cnt_d = stall_cnt_q + 32'd1;
            if (!bus.out_valid && bus.out_ready && (bubble_cnt_q != '1))
                bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

    // Upstream must hold its payload while a beat waits for acceptance.
    a_in_data_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        (bus.in_valid && !bus.in_ready && !flush_i) |=> (!bus.in_valid || $stable(bus.in_data))
    );

endmodule
